lcd_write_arbiter: RTL and testbench
====================================

// Module: lcd_write_arbiter
// PURPOSE
//  Shares the single LCD byte-write engine (lcd_controller: iDATA/iRS/iStart/oDone) among N requesters,
//  e.g. the debug hex display, a boot banner writer and a CPU MMIO port.
//  Round-robin grant; sequences start/done handshake and the post-write settle delay; acks the requester.
//  Sits between requester FSMs and lcd_controller, replacing each display block's private write sequencer.
// PARAMETERS
//  N_REQ          2      number of requesters (2..4)
//  SETTLE_CYCLES  41808  idle cycles after oDone before the next write (18'h0A350)
//  TIMEOUT_CYCLES 2**20  max cycles waiting for iLCD_DONE before abort
// PORTS
//  iCLK        in   1        clock
//  iRST_N      in   1        async reset, active-low
//  iREQ        in   N_REQ    write request, one per requester; held until oACK
//  iDATA       in   8*N_REQ  byte per requester, [8*i+7:8*i]; stable while iREQ[i]=1
//  iRS         in   N_REQ    register-select per requester (0 cmd, 1 data)
//  iLOCK       in   N_REQ    burst lock per requester (used only with LCD_ARB_LOCK_EN)
//  oGNT        out  N_REQ    one-hot owner of the current transaction
//  oACK        out  N_REQ    1-cycle pulse: owner's byte written and settled
//  oERR        out  1        1-cycle pulse: timeout abort (coincides with oACK of owner)
//  oBUSY       out  1        1 whenever state != IDLE
//  oLCD_DATA   out  8        to lcd_controller iDATA
//  oLCD_RS     out  1        to lcd_controller iRS
//  oLCD_START  out  1        to lcd_controller iStart
//  iLCD_DONE   in   1        from lcd_controller oDone
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE, rr pointer=0 (requester 0 highest priority), counters 0.
//  FSM: IDLE -> ISSUE -> WAIT_DONE -> SETTLE -> ACK -> IDLE.
//  IDLE: if |iREQ, winner = first set bit scanning from ptr upward with wrap; latch iDATA/iRS of winner
//   into oLCD_DATA/oLCD_RS; oGNT=onehot(winner); -> ISSUE. No request: stay, outputs hold last data.
//  ISSUE: oLCD_START<=1; -> WAIT_DONE (latency req->START = 2 cycles).
//  WAIT_DONE: hold oLCD_START=1 until iLCD_DONE=1; then oLCD_START<=0, -> SETTLE. Timeout counter
//   reaching TIMEOUT_CYCLES-1: oLCD_START<=0, set err flag, -> ACK (skip settle).
//  SETTLE: count 0..SETTLE_CYCLES-1, then -> ACK. SETTLE_CYCLES=0 passes through in 1 cycle.
//  ACK: oACK[winner]=1 and oERR=err for exactly 1 cycle; oGNT cleared; ptr<=winner+1 mod N_REQ; -> IDLE.
//  Requester may drop iREQ after oACK; re-asserting in the ACK cycle is ignored, seen in next IDLE.
//  iREQ dropped mid-transaction: write completes, oACK still issued (requester must tolerate).
//  iDATA changes after grant: ignored (latched copy used).
//  Simultaneous requests: strict round-robin; no requester waits more than N_REQ-1 transactions.
//  Reset mid-operation: immediate return to IDLE, oLCD_START deasserted, no oACK/oERR emitted.
// CONFIGURATION
//  `LCD_ARB_LOCK_EN defined: in ACK, if iLOCK[winner]=1 and iREQ[winner]=1 the ptr is NOT advanced and the
//   same requester wins the next IDLE arbitration (burst, e.g. full 34-byte screen refresh uninterrupted).
//   Lock ignored on a timed-out transaction (ptr always advances after oERR).
//  Undefined: iLOCK unused (tie-off tolerated), arbitration purely round-robin per byte.
// STRUCTURE
//  lcd_pkg: state enum (IDLE/ISSUE/WAIT_DONE/SETTLE/ACK), LCD_SETTLE_DEFAULT=18'h0A350,
//   LCD command constants (FUNC_SET 8'h38, DISP_ON 8'h0C, CLEAR 8'h01, ENTRY 8'h06, LINE1 8'h80, LINE2 8'hC0).
//  Sub-module rr_arbiter #(N): inputs req, ptr; output one-hot gnt, combinational; instantiated once.
// TESTING
//  Single req0 byte 8'h41 RS=1, DONE after 5 cycles -> START high cycles 2..7, oACK[0] after 41808 settle.
//  req0,req1 both held continuously -> grants alternate 0,1,0,1; each oACK pulse exactly 1 cycle.
//  iLCD_DONE never asserted, TIMEOUT_CYCLES=64 -> START drops at cycle 64 of WAIT_DONE, oERR+oACK same cycle.
//  `LCD_ARB_LOCK_EN, iLOCK[1]=1 with req0,req1 -> req1 gets 3 consecutive bytes, then req0 after lock drops.
//  Assert iRST_N=0 during SETTLE -> all outputs 0 next edge, no oACK; post-reset req1,req0 -> req0 first.
//  Change iDATA[7:0] from 8'h30 to 8'h31 one cycle after grant -> oLCD_DATA stays 8'h30.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write path: arbiter state encoding,
// default post-write settle delay and HD44780-style command bytes.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    SETTLE,
    ACK
  } lcd_arb_state_e;

  localparam logic [17:0] LCD_SETTLE_DEFAULT = 18'h0A350;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

endpackage

// File: rtl/lcd_write_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above i_ptr,
// wrapping to the lowest set request when nothing lies above the pointer.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_sel;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) w_mask[i] = (PW'(i) >= i_ptr);
  end

  assign w_hi  = i_req & w_mask;
  assign w_sel = (|w_hi) ? w_hi : i_req;
  // isolate lowest set bit
  assign o_gnt = w_sel & (~w_sel + N'(1));

endmodule

// File: rtl/lcd_write_arbiter.sv
// Round-robin sharing of one LCD byte-write engine among N_REQ requesters.
// Define LCD_ARB_LOCK_EN to let a locked requester keep ownership for bursts.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int          N_REQ          = 2,
  parameter int unsigned SETTLE_CYCLES  = {14'd0, LCD_SETTLE_DEFAULT},
  parameter int unsigned TIMEOUT_CYCLES = 32'h0010_0000
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [N_REQ-1:0]   iREQ,
  input  logic [8*N_REQ-1:0] iDATA,
  input  logic [N_REQ-1:0]   iRS,
  input  logic [N_REQ-1:0]   iLOCK,
  output logic [N_REQ-1:0]   oGNT,
  output logic [N_REQ-1:0]   oACK,
  output logic               oERR,
  output logic               oBUSY,
  output logic [7:0]         oLCD_DATA,
  output logic               oLCD_RS,
  output logic               oLCD_START,
  input  logic               iLCD_DONE
);

  localparam int PW = $clog2(N_REQ);

  lcd_arb_state_e r_state;
  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  r_win;
  logic [31:0]    r_cnt;
  logic           r_err;

  logic [N_REQ-1:0] w_gnt;
  logic [PW-1:0]    w_win_idx;
  logic [7:0]       w_data;
  logic             w_rs;
  logic [PW-1:0]    w_ptr_nxt;
  logic             w_keep;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .i_req (iREQ),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_win_idx = '0;
    w_data    = '0;
    w_rs      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_idx = PW'(i);
        w_data    = iDATA[8*i +: 8];
        w_rs      = iRS[i];
      end
    end
  end

  assign w_ptr_nxt = (r_win == PW'(N_REQ-1)) ? '0 : r_win + 1'b1;

`ifdef LCD_ARB_LOCK_EN
  // a timed-out owner always gives up the engine
  assign w_keep = ~r_err & iLOCK[r_win] & iREQ[r_win];
`else
  logic w_lock_unused;
  assign w_lock_unused = ^iLOCK;
  assign w_keep        = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_win      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      oGNT       <= '0;
      oACK       <= '0;
      oERR       <= 1'b0;
      oBUSY      <= 1'b0;
      oLCD_DATA  <= '0;
      oLCD_RS    <= 1'b0;
      oLCD_START <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|iREQ) begin
            oGNT      <= w_gnt;
            r_win     <= w_win_idx;
            oLCD_DATA <= w_data;
            oLCD_RS   <= w_rs;
            oBUSY     <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          oLCD_START <= 1'b1;
          r_cnt      <= '0;
          r_state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (iLCD_DONE) begin
            oLCD_START <= 1'b0;
            r_cnt      <= '0;
            r_state    <= SETTLE;
          end else if (r_cnt == TIMEOUT_CYCLES - 1) begin
            oLCD_START <= 1'b0;
            r_err      <= 1'b1;
            oACK       <= oGNT;
            oERR       <= 1'b1;
            r_state    <= ACK;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        SETTLE: begin
          if (SETTLE_CYCLES == 0 || r_cnt == SETTLE_CYCLES - 1) begin
            oACK    <= oGNT;
            oERR    <= r_err;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ACK: begin
          oACK    <= '0;
          oERR    <= 1'b0;
          oGNT    <= '0;
          oBUSY   <= 1'b0;
          r_err   <= 1'b0;
          r_ptr   <= w_keep ? r_win : w_ptr_nxt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: single write, latched data, timeout,
// reset during settle, round-robin alternation and burst lock.
module tb_lcd_write_arbiter;

  localparam int N   = 2;
  localparam int SET = 20;
  localparam int TMO = 64;

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic [N-1:0]  iREQ, iRS, iLOCK;
  logic [8*N-1:0] iDATA;
  logic [N-1:0]  oGNT, oACK;
  logic          oERR, oBUSY, oLCD_RS, oLCD_START, iLCD_DONE;
  logic [7:0]    oLCD_DATA;

  int n_vec = 0;
  int n_err = 0;

  always #5 iCLK = ~iCLK;

  lcd_write_arbiter #(.N_REQ(N), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TMO)) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iREQ       (iREQ),
    .iDATA      (iDATA),
    .iRS        (iRS),
    .iLOCK      (iLOCK),
    .oGNT       (oGNT),
    .oACK       (oACK),
    .oERR       (oERR),
    .oBUSY      (oBUSY),
    .oLCD_DATA  (oLCD_DATA),
    .oLCD_RS    (oLCD_RS),
    .oLCD_START (oLCD_START),
    .iLCD_DONE  (iLCD_DONE)
  );

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction with requests already pending; eg is the expected owner.
  task automatic run_txn(input logic [1:0] eg, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (oGNT != '0) begin seen = 1'b1; break; end
    end
    chk({tag, "_gnt_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_gnt"}, {30'd0, oGNT}, {30'd0, eg});
    chk({tag, "_data"}, {24'd0, oLCD_DATA}, (eg == 2'b01) ? 32'hA0 : 32'hB1);
    chk({tag, "_rs"}, {31'd0, oLCD_RS}, {31'd0, eg[1]});
    tick();
    chk({tag, "_start"}, {31'd0, oLCD_START}, 32'd1);
    iLCD_DONE = 1'b1;
    tick();
    iLCD_DONE = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (oACK != '0) begin seen = 1'b1; break; end
    end
    chk({tag, "_ack_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_ack"}, {30'd0, oACK}, {30'd0, eg});
    tick();
    chk({tag, "_ack_pulse"}, {30'd0, oACK}, 32'd0);
  endtask

  initial begin
    int   n_hi;
    int   n_set;
    logic seen;
    logic ack_seen;

    iRST_N = 1'b0; iREQ = '0; iDATA = '0; iRS = '0; iLOCK = '0; iLCD_DONE = 1'b0;
    tick(); tick();
    chk("rst_gnt",   {30'd0, oGNT}, 32'd0);
    chk("rst_ack",   {30'd0, oACK}, 32'd0);
    chk("rst_err",   {31'd0, oERR}, 32'd0);
    chk("rst_busy",  {31'd0, oBUSY}, 32'd0);
    chk("rst_data",  {24'd0, oLCD_DATA}, 32'd0);
    chk("rst_start", {31'd0, oLCD_START}, 32'd0);
    iRST_N = 1'b1;
    tick();

    // single write, requester 0, byte 'A' as data
    iDATA = 16'h0041; iRS = 2'b01; iREQ = 2'b01;
    tick();
    chk("t1_gnt",   {30'd0, oGNT}, 32'd1);
    chk("t1_data",  {24'd0, oLCD_DATA}, 32'h41);
    chk("t1_rs",    {31'd0, oLCD_RS}, 32'd1);
    chk("t1_busy",  {31'd0, oBUSY}, 32'd1);
    chk("t1_start0",{31'd0, oLCD_START}, 32'd0);
    tick();
    n_hi = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      if (oLCD_START === 1'b1) n_hi++;
    end
    iLCD_DONE = 1'b1;
    tick();
    iLCD_DONE = 1'b0;
    chk("t1_start_hi",   n_hi, 32'd5);
    chk("t1_start_drop", {31'd0, oLCD_START}, 32'd0);
    n_set = 0; seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      n_set++;
      if (oACK != '0) begin seen = 1'b1; break; end
    end
    chk("t1_ack_seen", {31'd0, seen}, 32'd1);
    chk("t1_settle",   n_set, SET);
    chk("t1_ack",      {30'd0, oACK}, 32'd1);
    chk("t1_err",      {31'd0, oERR}, 32'd0);
    iREQ = 2'b00;
    tick();
    chk("t1_ack_off",  {30'd0, oACK}, 32'd0);
    chk("t1_gnt_off",  {30'd0, oGNT}, 32'd0);
    chk("t1_busy_off", {31'd0, oBUSY}, 32'd0);

    // data changes after grant must not reach the LCD
    iDATA = 16'h0030; iREQ = 2'b01;
    tick();
    chk("t2_gnt",  {30'd0, oGNT}, 32'd1);
    chk("t2_data", {24'd0, oLCD_DATA}, 32'h30);
    iDATA = 16'h0031;
    tick();
    chk("t2_data_held", {24'd0, oLCD_DATA}, 32'h30);
    iLCD_DONE = 1'b1;
    tick();
    iLCD_DONE = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (oACK != '0) begin seen = 1'b1; break; end
    end
    chk("t2_ack_seen",  {31'd0, seen}, 32'd1);
    chk("t2_data_ack",  {24'd0, oLCD_DATA}, 32'h30);
    iREQ = 2'b00;
    tick();

    // done never comes: abort after TMO cycles of WAIT_DONE
    iDATA = 16'h0055; iRS = 2'b00; iREQ = 2'b01;
    tick();
    chk("t3_gnt", {30'd0, oGNT}, 32'd1);
    tick();
    n_hi = 0;
    for (int k = 0; k < 200; k++) begin
      if (oLCD_START === 1'b1) n_hi++;
      else break;
      tick();
    end
    chk("t3_start_hi", n_hi, TMO);
    chk("t3_ack",      {30'd0, oACK}, 32'd1);
    chk("t3_err",      {31'd0, oERR}, 32'd1);
    iREQ = 2'b00;
    tick();
    chk("t3_ack_off",  {30'd0, oACK}, 32'd0);
    chk("t3_err_off",  {31'd0, oERR}, 32'd0);

    // reset while requester 1 is settling
    iDATA = 16'hC200; iRS = 2'b10; iREQ = 2'b10;
    tick();
    chk("t4_gnt", {30'd0, oGNT}, 32'd2);
    tick();
    iLCD_DONE = 1'b1;
    tick();
    iLCD_DONE = 1'b0;
    repeat (5) tick();
    chk("t4_busy", {31'd0, oBUSY}, 32'd1);
    iRST_N = 1'b0;
    #1;
    chk("t4_rst_gnt",   {30'd0, oGNT}, 32'd0);
    chk("t4_rst_busy",  {31'd0, oBUSY}, 32'd0);
    chk("t4_rst_data",  {24'd0, oLCD_DATA}, 32'd0);
    iREQ = 2'b00;
    tick();
    chk("t4_rst_start", {31'd0, oLCD_START}, 32'd0);
    chk("t4_rst_ack",   {30'd0, oACK}, 32'd0);
    iRST_N = 1'b1;
    ack_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      ack_seen = ack_seen | (|oACK) | oERR;
    end
    chk("t4_no_ack", {31'd0, ack_seen}, 32'd0);

    // both requesters held: pointer was reset so requester 0 goes first
    iDATA = 16'hB1A0; iRS = 2'b10; iLOCK = 2'b00; iREQ = 2'b11;
    run_txn(2'b01, "t5a");
    run_txn(2'b10, "t5b");
    run_txn(2'b01, "t5c");
    run_txn(2'b10, "t5d");

    // requester 1 asserts lock for a burst, then releases it
    iLOCK = 2'b10;
    run_txn(2'b01, "t6a");
    run_txn(2'b10, "t6b");
`ifdef LCD_ARB_LOCK_EN
    run_txn(2'b10, "t6c");
    iLOCK = 2'b00;
    run_txn(2'b10, "t6d");
    run_txn(2'b01, "t6e");
`else
    run_txn(2'b01, "t6c");
    iLOCK = 2'b00;
    run_txn(2'b10, "t6d");
    run_txn(2'b01, "t6e");
`endif
    iREQ = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
